// File: rtl/alu_mul_ctrl_if.sv
// alu_mul_ctrl_if: start/busy/done handshake and operand/product bus between
// the surrounding datapath (master) and the multiply sequencer (slave).
//   start  master->slave  request, sampled only while the sequencer is idle
//   A, B   master->slave  multiplicand / multiplier, latched on accept
//   busy   slave->master  multiply in progress
//   done   slave->master  one-cycle pulse, P valid
//   P      slave->master  2*WIDTH-bit product, held until the next DONE
interface alu_mul_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     P;

    modport master (
        output start, A, B,
        input  busy, done, P
    );

    modport slave (
        input  start, A, B,
        output busy, done, P
    );
endinterface

// File: rtl/alu_mul_ctrl.sv
// alu_mul_ctrl: unsigned WIDTH x WIDTH shift-and-add multiply sequencer that
// borrows the shared combinational ALU for its ADD operation only.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (abandons any multiply)
//   bus       alu_mul_ctrl_if.slave: start, A, B in; busy, done, P out
//   alu_a     ALU A operand (accumulator)
//   alu_b     ALU B operand (multiplicand when Q[0]=1, else zero)
//   alu_cin   ALU carry-in, always 0
//   alu_s     ALU select, always ADD_OP
//   alu_f     ALU result
//   alu_cout  ALU carry-out
// One multiply: accept, WIDTH x (ADD, SHIFT), DONE; 2*WIDTH+2 cycles each.
module alu_mul_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter logic [1:0]  ADD_OP = 2'b11
) (
    input  logic               clk,
    input  logic               rst,
    alu_mul_ctrl_if.slave      bus,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_cin,
    output logic [1:0]         alu_s,
    input  logic [WIDTH-1:0]   alu_f,
    input  logic               alu_cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     m, m_n;
    logic [WIDTH-1:0]     q, q_n;
    logic [WIDTH-1:0]     acc, acc_n;
    logic                 c, c_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2*WIDTH-1:0]   p, p_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            q     <= '0;
            acc   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            state <= state_n;
            m     <= m_n;
            q     <= q_n;
            acc   <= acc_n;
            c     <= c_n;
            cnt   <= cnt_n;
            p     <= p_n;
        end
    end

    always_comb begin
        state_n = state;
        m_n     = m;
        q_n     = q;
        acc_n   = acc;
        c_n     = c;
        cnt_n   = cnt;
        p_n     = p;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    m_n     = bus.A;
                    q_n     = bus.B;
                    acc_n   = '0;
                    c_n     = 1'b0;
                    cnt_n   = '0;
                    state_n = ADD;
                end
            end
            ADD: begin
                // alu_b is already zero when Q[0]=0, so this step is unconditional
                {c_n, acc_n} = {alu_cout, alu_f};
                state_n      = SHIFT;
            end
            SHIFT: begin
                // carry re-enters at the top so the full 2*WIDTH product is kept
                acc_n = {c, acc[WIDTH-1:1]};
                q_n   = {acc[0], q[WIDTH-1:1]};
                c_n   = 1'b0;
                if (cnt == CNT_LAST) begin
                    // post-shift {ACC, Q}, formed from pre-shift registers
                    p_n     = {c, acc, q[WIDTH-1:1]};
                    state_n = DONE;
                end else begin
                    cnt_n   = cnt + 1'b1;
                    state_n = ADD;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign alu_a   = acc;
    assign alu_b   = q[0] ? m : '0;
    assign alu_cin = 1'b0;
    assign alu_s   = ADD_OP;

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.P    = p;

endmodule
